// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and helpers for the uart transmit arbiter
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        HOLD
    } arb_state_t;

    // Counter must be able to represent the full timeout value.
    function automatic int timeout_cnt_w(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin pick: first set request at or after ptr
module rr_select #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_in,
    input  logic [PW-1:0] ptr_in,
    output logic [N-1:0]  gnt_out,
    output logic [PW-1:0] idx_out,
    output logic          any_out
);

    always_comb begin
        logic [PW-1:0] cand;
        gnt_out = '0;
        idx_out = '0;
        any_out = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = PW'((int'(ptr_in) + i) % N);
            if (!any_out && req_in[cand]) begin
                any_out       = 1'b1;
                gnt_out[cand] = 1'b1;
                idx_out       = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart transmitter between byte producers
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [NUM_PORTS-1:0]      req_valid_in,
    input  logic [NUM_PORTS-1:0][7:0] req_data_in,
    input  logic [NUM_PORTS-1:0]      req_last_in,
    output logic [NUM_PORTS-1:0]      req_ready_out,
    output logic [7:0]                tx_data_out,
    output logic                      tx_trigger_out,
    input  logic                      tx_busy_in,
    output logic [NUM_PORTS-1:0]      grant_out,
    output logic                      err_out
);

    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int CNT_W  = timeout_cnt_w(BUSY_TIMEOUT);

    arb_state_t           state_q, state_d;
    logic [PORT_W-1:0]    ptr_q, ptr_d;
    logic [PORT_W-1:0]    owner_q, owner_d;
    logic                 lock_q, lock_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           data_q, data_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic                 err_q, err_d;

    logic [NUM_PORTS-1:0] sel_gnt;
    logic [PORT_W-1:0]    sel_idx;
    logic                 sel_any;

    rr_select #(
        .N  (NUM_PORTS),
        .PW (PORT_W)
    ) u_rr_select (
        .req_in  (req_valid_in),
        .ptr_in  (ptr_q),
        .gnt_out (sel_gnt),
        .idx_out (sel_idx),
        .any_out (sel_any)
    );

    function automatic logic [PORT_W-1:0] wrap_inc(input logic [PORT_W-1:0] p);
        return (p == PORT_W'(NUM_PORTS - 1)) ? '0 : p + PORT_W'(1);
    endfunction

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            grant_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        owner_d        = owner_q;
        lock_d         = lock_q;
        cnt_d          = cnt_q;
        data_d         = data_q;
        grant_d        = grant_q;
        err_d          = err_q;
        req_ready_out  = '0;
        tx_trigger_out = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    req_ready_out = sel_gnt;
                    data_d        = req_data_in[sel_idx];
                    grant_d       = sel_gnt;
                    owner_d       = sel_idx;
                    lock_d        = !req_last_in[sel_idx];
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                tx_trigger_out = 1'b1;
                cnt_d          = '0;
                state_d        = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy_in) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    // Transmitter never acknowledged: drop the packet and move on.
                    err_d   = 1'b1;
                    lock_d  = 1'b0;
                    grant_d = '0;
                    ptr_d   = wrap_inc(owner_q);
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy_in) begin
                    if (lock_q) begin
                        state_d = HOLD;
                    end else begin
                        ptr_d   = wrap_inc(owner_q);
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (req_valid_in[owner_q]) begin
                    req_ready_out = grant_q;
                    data_d        = req_data_in[owner_q];
                    lock_d        = !req_last_in[owner_q];
                    state_d       = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_data_out = data_q;
    assign grant_out   = grant_q;
    assign err_out     = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench: uart transmitter model, serial monitor, directed packets
module tb_uart_tx_arbiter;

    localparam int N       = 4;
    localparam int BT      = 8;
    localparam int BIT_CYC = 10;

    logic                clk_in = 1'b0;
    logic                rst_in = 1'b1;
    logic [N-1:0]        req_valid_in;
    logic [N-1:0][7:0]   req_data_in;
    logic [N-1:0]        req_last_in;
    logic [N-1:0]        req_ready_out;
    logic [7:0]          tx_data_out;
    logic                tx_trigger_out;
    logic                tx_busy_in;
    logic [N-1:0]        grant_out;
    logic                err_out;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fire_cyc = 0;
    int acc_cnt [N] = '{default: 0};
    logic [7:0] exp_q [$];
    logic [8:0] pq [N][$];

    logic       stub = 1'b0;
    logic       tx_busy;
    logic       tx_line;
    logic [9:0] tx_shreg;
    logic [3:0] tx_bit;
    logic [3:0] tx_cyc;

    assign tx_busy_in = tx_busy;

    uart_tx_arbiter #(
        .NUM_PORTS    (N),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .req_valid_in   (req_valid_in),
        .req_data_in    (req_data_in),
        .req_last_in    (req_last_in),
        .req_ready_out  (req_ready_out),
        .tx_data_out    (tx_data_out),
        .tx_trigger_out (tx_trigger_out),
        .tx_busy_in     (tx_busy_in),
        .grant_out      (grant_out),
        .err_out        (err_out)
    );

    initial forever #5 clk_in = ~clk_in;
    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Behavioural transmitter, 10 clocks per bit, 8N1; stub mode never raises busy.
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tx_busy  <= 1'b0;
            tx_line  <= 1'b1;
            tx_shreg <= '1;
            tx_bit   <= '0;
            tx_cyc   <= '0;
        end else if (!tx_busy) begin
            if (tx_trigger_out && !stub) begin
                tx_busy  <= 1'b1;
                tx_shreg <= {1'b1, tx_data_out, 1'b0};
                tx_line  <= 1'b0;
                tx_bit   <= '0;
                tx_cyc   <= '0;
            end
        end else if (tx_cyc == 4'(BIT_CYC - 1)) begin
            tx_cyc <= '0;
            if (tx_bit == 4'd9) begin
                tx_busy <= 1'b0;
                tx_line <= 1'b1;
            end else begin
                tx_bit  <= tx_bit + 4'd1;
                tx_line <= tx_shreg[tx_bit + 4'd1];
            end
        end else begin
            tx_cyc <= tx_cyc + 4'd1;
        end
    end

    // Serial monitor: decodes frames mid-bit and compares against the scoreboard.
    initial begin : monitor
        int         mcnt;
        logic       active;
        logic [7:0] sh;
        logic [7:0] exp_b;
        mcnt = 0;
        active = 1'b0;
        sh = '0;
        exp_b = '0;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                active = 1'b0;
            end else if (!active) begin
                if (tx_line == 1'b0) begin
                    active = 1'b1;
                    mcnt = 0;
                end
            end else begin
                mcnt++;
                if (mcnt >= 15 && mcnt < 95 && (mcnt % 10) == 5)
                    sh = {tx_line, sh[7:1]};
                if (mcnt == 95) begin
                    active = 1'b0;
                    check("wire_stop_bit", tx_line, 1'b1);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL wire_byte: got %0h expected none", sh);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (sh !== exp_b) begin
                            errors++;
                            $display("FAIL wire_byte: got %0h expected %0h", sh, exp_b);
                        end
                    end
                end
            end
        end
    end

    // Producer driver: presents each port's queue head, pops on valid&ready.
    initial begin : driver
        logic [N-1:0] fire;
        logic [8:0]   head;
        req_valid_in = '0;
        req_data_in  = '0;
        req_last_in  = '0;
        forever begin
            @(negedge clk_in);
            fire = req_valid_in & req_ready_out & {N{!rst_in}};
            if (fire != '0) fire_cyc = cyc;
            if (req_ready_out != '0) begin
                check("ready_onehot", 32'($onehot(req_ready_out)), 1);
                check("ready_needs_valid", 32'(req_ready_out & ~req_valid_in), 0);
            end
            @(posedge clk_in);
            #1;
            for (int p = 0; p < N; p++) begin
                if (fire[p]) begin
                    void'(pq[p].pop_front());
                    acc_cnt[p]++;
                end
                if (pq[p].size() > 0) begin
                    head = pq[p][0];
                    req_valid_in[p] = 1'b1;
                    req_data_in[p]  = head[7:0];
                    req_last_in[p]  = head[8];
                end else begin
                    req_valid_in[p] = 1'b0;
                end
            end
        end
    end

    function automatic int pending();
        int s = 0;
        for (int p = 0; p < N; p++) s += pq[p].size();
        return s;
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        repeat (2) @(negedge clk_in);
        while (n < 4000 && (exp_q.size() != 0 || pending() != 0 || grant_out != '0 ||
                            tx_busy_in || req_valid_in != '0 || tx_trigger_out)) begin
            @(negedge clk_in);
            n++;
        end
        check({name, "_idle_reached"}, 32'(n < 4000), 1);
    endtask

    task automatic wait_trig(input string name);
        int n = 0;
        while (n < 4000 && !tx_trigger_out) begin
            @(negedge clk_in);
            n++;
        end
        check(name, 32'(n < 4000), 1);
    endtask

    task automatic wait_acc(input int p, input int target, input string name);
        int n = 0;
        while (n < 4000 && acc_cnt[p] < target) begin
            @(negedge clk_in);
            n++;
        end
        check(name, 32'(n < 4000), 1);
    endtask

    initial begin : stimulus
        int a0, a1, a2, a3, n;
        repeat (3) @(negedge clk_in);
        check("rst_tx_data", 32'(tx_data_out), 0);
        check("rst_trigger", 32'(tx_trigger_out), 0);
        check("rst_ready", 32'(req_ready_out), 0);
        check("rst_grant", 32'(grant_out), 0);
        check("rst_err", 32'(err_out), 0);
        rst_in = 1'b0;

        // Single byte from port 2
        @(negedge clk_in);
        a2 = acc_cnt[2];
        exp_q.push_back(8'hA5);
        pq[2].push_back({1'b1, 8'hA5});
        wait_trig("t1_trigger_seen");
        check("t1_trig_latency", 32'(cyc - fire_cyc), 1);
        check("t1_tx_data", 32'(tx_data_out), 32'hA5);
        check("t1_grant", 32'(grant_out), 32'b0100);
        check("t1_ready_pulses", 32'(acc_cnt[2] - a2), 1);
        @(negedge clk_in);
        check("t1_trig_width", 32'(tx_trigger_out), 0);
        wait_idle("t1");
        check("t1_grant_clear", 32'(grant_out), 0);
        check("t1_data_hold", 32'(tx_data_out), 32'hA5);

        // Pointer now 3: port 3 beats port 0
        @(negedge clk_in);
        exp_q.push_back(8'h23);
        exp_q.push_back(8'h20);
        pq[0].push_back({1'b1, 8'h20});
        pq[3].push_back({1'b1, 8'h23});
        wait_idle("t1b");

        // Contention from reset
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        a0 = acc_cnt[0]; a1 = acc_cnt[1]; a3 = acc_cnt[3];
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h13);
        pq[0].push_back({1'b1, 8'h10});
        pq[1].push_back({1'b1, 8'h11});
        pq[3].push_back({1'b1, 8'h13});
        wait_idle("t2");
        check("t2_p0_once", 32'(acc_cnt[0] - a0), 1);
        check("t2_p1_once", 32'(acc_cnt[1] - a1), 1);
        check("t2_p3_once", 32'(acc_cnt[3] - a3), 1);

        // Packet lock: port 1 two-byte packet, port 0 waiting
        a0 = acc_cnt[0]; a1 = acc_cnt[1];
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h49);
        exp_q.push_back(8'h30);
        pq[1].push_back({1'b0, 8'h48});
        pq[1].push_back({1'b1, 8'h49});
        wait_acc(1, a1 + 1, "t3_first_accept");
        pq[0].push_back({1'b1, 8'h30});
        wait_acc(1, a1 + 2, "t3_second_accept");
        check("t3_p0_blocked", 32'(acc_cnt[0] - a0), 0);
        wait_idle("t3");
        check("t3_p0_served", 32'(acc_cnt[0] - a0), 1);

        // HOLD stall: owner goes quiet for 500 cycles
        a1 = acc_cnt[1]; a2 = acc_cnt[2];
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h62);
        pq[1].push_back({1'b0, 8'h41});
        wait_acc(1, a1 + 1, "t4_first_accept");
        pq[2].push_back({1'b1, 8'h62});
        repeat (500) @(negedge clk_in);
        check("t4_hold_grant", 32'(grant_out), 32'b0010);
        check("t4_hold_ready", 32'(req_ready_out), 0);
        check("t4_p2_waiting", 32'(acc_cnt[2] - a2), 0);
        pq[1].push_back({1'b1, 8'h42});
        wait_idle("t4");
        check("t4_p2_served", 32'(acc_cnt[2] - a2), 1);

        // Busy timeout with a dead transmitter
        stub = 1'b1;
        pq[3].push_back({1'b1, 8'h55});
        wait_trig("t5_trigger_seen");
        repeat (BT) @(negedge clk_in);
        check("t5_err_not_early", 32'(err_out), 0);
        @(negedge clk_in);
        check("t5_err_set", 32'(err_out), 1);
        check("t5_grant_clear", 32'(grant_out), 0);
        stub = 1'b0;
        exp_q.push_back(8'h66);
        pq[0].push_back({1'b1, 8'h66});
        wait_idle("t5");
        check("t5_err_sticky", 32'(err_out), 1);
        check("t5_next_data", 32'(tx_data_out), 32'h66);

        // Asynchronous reset in the middle of a byte
        pq[2].push_back({1'b1, 8'h99});
        n = 0;
        while (n < 4000 && !tx_busy_in) begin
            @(negedge clk_in);
            n++;
        end
        check("t6_busy_seen", 32'(n < 4000), 1);
        repeat (20) @(negedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        check("t6_rst_tx_data", 32'(tx_data_out), 0);
        check("t6_rst_trigger", 32'(tx_trigger_out), 0);
        check("t6_rst_ready", 32'(req_ready_out), 0);
        check("t6_rst_grant", 32'(grant_out), 0);
        check("t6_rst_err", 32'(err_out), 0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h78);
        pq[1].push_back({1'b1, 8'h78});
        pq[0].push_back({1'b1, 8'h77});
        wait_idle("t6");

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
